// File: rtl/ifetch_if.sv
// Fetch unit bus bundle: ROM request/response, redirect and decoder-side queue head.
interface ifetch_if;
    logic [15:0] iread_addr;
    logic [23:0] iread_data;
    logic        iread_valid;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [1:0]  consume;
    logic [23:0] out_bytes;
    logic [4:0]  out_count;
    logic [15:0] pc;

    modport master (
        output iread_addr, out_bytes, out_count, pc,
        input  iread_data, iread_valid, redirect, redirect_pc, consume
    );

    modport slave (
        input  iread_addr, out_bytes, out_count, pc,
        output iread_data, iread_valid, redirect, redirect_pc, consume
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch byte queue: 3-byte ROM fetches feeding a variable-length decoder.
// Optional IFETCH_PERF_EN adds perf_fetches / perf_stalls counters.
module ifetch #(
    parameter logic [15:0] RESET_PC = 16'h4000,
    parameter int          DEPTH    = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    ifetch_if.master    bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [15:0] perf_fetches,
    output logic [15:0] perf_stalls
`endif
);

    localparam logic [5:0] DEPTH6 = 6'(DEPTH);

    logic [7:0]  qbuf_q [DEPTH];
    logic [7:0]  qbuf_d [DEPTH];
    logic [4:0]  count_q, count_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] fetch_q, fetch_d;
    logic [15:0] req_q, req_d;
    logic        issue_q, issue_d;

    logic [4:0]  eff;
    logic [4:0]  keep;
    logic [5:0]  need;
    logic        cap, lost, issue;

    always_comb begin
        eff  = ({3'b0, bus.consume} > count_q) ? count_q : {3'b0, bus.consume};
        keep = count_q - eff;
        cap  = issue_q && bus.iread_valid && !bus.redirect;
        lost = issue_q && !bus.iread_valid && !bus.redirect;
        need = 6'(keep) + (cap ? 6'd3 : 6'd0) + 6'd3;
        issue = !bus.redirect && !lost && (need <= DEPTH6);
    end

    // Head shifts down by the consumed amount; a capture lands right after the survivors.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            int src;
            int lane;
            src  = i + int'(eff);
            lane = i - int'(keep);
            qbuf_d[i] = (src < DEPTH) ? qbuf_q[src] : 8'h00;
            if (cap && lane >= 0 && lane < 3)
                qbuf_d[i] = bus.iread_data[lane*8 +: 8];
        end
    end

    always_comb begin
        count_d = keep + (cap ? 5'd3 : 5'd0);
        pc_d    = pc_q + 16'(eff);
        fetch_d = fetch_q;
        req_d   = req_q;
        issue_d = issue;
        if (bus.redirect) begin
            count_d = 5'd0;
            pc_d    = bus.redirect_pc;
            fetch_d = bus.redirect_pc;
        end else if (lost) begin
            fetch_d = req_q;
        end else if (issue) begin
            fetch_d = fetch_q + 16'd3;
            req_d   = fetch_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                qbuf_q[i] <= 8'h00;
            count_q <= 5'd0;
            pc_q    <= RESET_PC;
            fetch_q <= RESET_PC;
            req_q   <= RESET_PC;
            issue_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                qbuf_q[i] <= qbuf_d[i];
            count_q <= count_d;
            pc_q    <= pc_d;
            fetch_q <= fetch_d;
            req_q   <= req_d;
            issue_q <= issue_d;
        end
    end

    // Lanes past the valid count read as zero so the decoder never sees stale bytes.
    always_comb begin
        for (int i = 0; i < 3; i++)
            bus.out_bytes[i*8 +: 8] = (count_q > 5'(i)) ? qbuf_q[i] : 8'h00;
    end

    assign bus.iread_addr = fetch_q;
    assign bus.out_count  = count_q;
    assign bus.pc         = pc_q;

    always_ff @(posedge clk) begin
        if (reset_n && !bus.redirect)
            assert ({3'b0, bus.consume} <= count_q)
            else $warning("ifetch: consume %0d clamped to %0d", bus.consume, count_q);
    end

`ifdef IFETCH_PERF_EN
    logic [15:0] fetches_q, stalls_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetches_q <= 16'd0;
            stalls_q  <= 16'd0;
        end else begin
            if (cap)
                fetches_q <= fetches_q + 16'd1;
            if (count_q == 5'd0 && !bus.redirect)
                stalls_q <= stalls_q + 16'd1;
        end
    end

    assign perf_fetches = fetches_q;
    assign perf_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: directed cycle vectors push expectations, a negedge monitor checks.
module tb_ifetch;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    ifetch_if bus ();

`ifdef IFETCH_PERF_EN
    logic [15:0] perf_fetches, perf_stalls;
    ifetch #(.RESET_PC(16'h4000), .DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .perf_fetches(perf_fetches), .perf_stalls(perf_stalls)
    );
`else
    ifetch #(.RESET_PC(16'h4000), .DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rb(logic [15:0] a);
        case (a)
            16'h4000: return 8'h11;
            16'h4001: return 8'h22;
            16'h4002: return 8'h33;
            16'h4003: return 8'h44;
            16'h4004: return 8'h55;
            16'h4005: return 8'h66;
            default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [23:0] lanes(logic [15:0] p, int c);
        logic [23:0] r;
        r = 24'h0;
        for (int i = 0; i < 3; i++)
            if (i < c) r[i*8 +: 8] = rb(p + 16'(i));
        return r;
    endfunction

    // ROM responder: samples the address on posedge, answers the following cycle
    logic [15:0] rom_a = 16'h0;
    always @(posedge clk) rom_a <= bus.iread_addr;
    assign bus.iread_data = {rb(rom_a + 16'd2), rb(rom_a + 16'd1), rb(rom_a)};

    typedef struct {
        int          cyc;
        string       nm;
        logic [15:0] pc;
        logic [4:0]  cnt;
        logic [15:0] addr;
        logic [23:0] by;
    } exp_t;

    exp_t sbq[$];

    task automatic ex(string nm, logic [15:0] p, logic [4:0] c,
                      logic [15:0] a, logic [23:0] b);
        exp_t e;
        e.cyc = cyc; e.nm = nm; e.pc = p; e.cnt = c; e.addr = a; e.by = b;
        sbq.push_back(e);
    endtask

    task automatic chk(string nm, string fld, logic [23:0] act, logic [23:0] exv);
        n_cmp++;
        if (act !== exv) begin
            n_bad++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exv);
        end
    endtask

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            if (e.cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d seen at %0d", e.nm, e.cyc, cyc);
            end else begin
                chk(e.nm, "pc",    24'(bus.pc),        24'(e.pc));
                chk(e.nm, "count", 24'(bus.out_count), 24'(e.cnt));
                chk(e.nm, "addr",  24'(bus.iread_addr), 24'(e.addr));
                chk(e.nm, "bytes", bus.out_bytes,      e.by);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(logic [1:0] c, logic v, logic r, logic [15:0] rp);
        bus.consume     = c;
        bus.iread_valid = v;
        bus.redirect    = r;
        bus.redirect_pc = rp;
    endtask

    initial begin
        reset_n = 1'b0;
        drv(2'd0, 1'b1, 1'b0, 16'h0);
        tick(); tick();
        ex("reset", 16'h4000, 5'd0, 16'h4000, 24'h0);
        tick();
        reset_n = 1'b1;

        ex("boot1", 16'h4000, 5'd0, 16'h4000, 24'h0);          tick();
        ex("boot2", 16'h4000, 5'd0, 16'h4003, 24'h0);          tick();
        ex("boot3", 16'h4000, 5'd3, 16'h4006, 24'h332211);     tick();
        ex("boot4", 16'h4000, 5'd6, 16'h4006, 24'h332211);     tick();
        ex("full",  16'h4000, 5'd6, 16'h4006, 24'h332211);
        drv(2'd3, 1'b1, 1'b0, 16'h0);                          tick();
        ex("cons1", 16'h4003, 5'd3, 16'h4009, 24'h665544);
        drv(2'd3, 1'b0, 1'b0, 16'h0);                          tick();
        ex("lost1", 16'h4006, 5'd0, 16'h4006, 24'h0);
        drv(2'd0, 1'b1, 1'b0, 16'h0);                          tick();
        ex("lost2", 16'h4006, 5'd0, 16'h4009, 24'h0);          tick();
        ex("refl",  16'h4006, 5'd3, 16'h400C, lanes(16'h4006, 3));
        drv(2'd3, 1'b1, 1'b0, 16'h0);                          tick();
        ex("strm1", 16'h4009, 5'd3, 16'h400F, lanes(16'h4009, 3)); tick();
        ex("strm2", 16'h400C, 5'd3, 16'h4012, lanes(16'h400C, 3)); tick();
        ex("strm3", 16'h400F, 5'd3, 16'h4015, lanes(16'h400F, 3));
        drv(2'd3, 1'b1, 1'b1, 16'h4100);                       tick();
        ex("redir", 16'h4100, 5'd0, 16'h4100, 24'h0);
        drv(2'd0, 1'b1, 1'b0, 16'h0);                          tick();
        ex("rdr2",  16'h4100, 5'd0, 16'h4103, 24'h0);          tick();
        ex("rdr3",  16'h4100, 5'd3, 16'h4106, lanes(16'h4100, 3));
        drv(2'd0, 1'b1, 1'b1, 16'hFFFE);                       tick();
        ex("wrap0", 16'hFFFE, 5'd0, 16'hFFFE, 24'h0);
        drv(2'd0, 1'b1, 1'b0, 16'h0);                          tick();
        ex("wrap1", 16'hFFFE, 5'd0, 16'h0001, 24'h0);          tick();
        ex("wrap2", 16'hFFFE, 5'd3, 16'h0004, lanes(16'hFFFE, 3));
        drv(2'd1, 1'b1, 1'b0, 16'h0);                          tick();
        ex("wrap3", 16'hFFFF, 5'd5, 16'h0007, lanes(16'hFFFF, 3)); tick();
        ex("wrap4", 16'h0000, 5'd7, 16'h0007, lanes(16'h0000, 3));
        drv(2'd0, 1'b1, 1'b1, 16'h5000);                       tick();
        ex("clmp0", 16'h5000, 5'd0, 16'h5000, 24'h0);
        drv(2'd0, 1'b1, 1'b0, 16'h0);                          tick();
        ex("clmp1", 16'h5000, 5'd0, 16'h5003, 24'h0);          tick();
        ex("clmp2", 16'h5000, 5'd3, 16'h5006, lanes(16'h5000, 3));
        drv(2'd1, 1'b0, 1'b0, 16'h0);                          tick();
        ex("part",  16'h5001, 5'd2, 16'h5003, lanes(16'h5001, 2));
        drv(2'd3, 1'b1, 1'b0, 16'h0);                          tick();
        ex("clamp", 16'h5003, 5'd0, 16'h5006, 24'h0);
        drv(2'd0, 1'b1, 1'b0, 16'h0);                          tick();
        ex("clmp4", 16'h5003, 5'd3, 16'h5009, lanes(16'h5003, 3)); tick();
        reset_n = 1'b0;
        ex("mrst",  16'h4000, 5'd0, 16'h4000, 24'h0);          tick();
        reset_n = 1'b1;
        ex("rbt1",  16'h4000, 5'd0, 16'h4000, 24'h0);          tick();
        ex("rbt2",  16'h4000, 5'd0, 16'h4003, 24'h0);          tick();
        ex("rbt3",  16'h4000, 5'd3, 16'h4006, 24'h332211);     tick();

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
